pipe_hazard_stall: RTL and testbench

//  Producer-side counterpart to the EX/MEM/WB operand forwarding path. Sits in ID
//  and decides when the front end must stall because forwarding cannot deliver an

---
 rtl/pipe_hazard_stall_if.sv | 47 ++++
 rtl/pipe_hazard_stall.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_stall.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_stall_if.sv
// pipe_hazard_stall_if
//  Bundles the ID/EX hazard-detection signals between the pipeline datapath
//  (master) and the stall unit (slave).
//  master drives : IFID_Valid, IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRs,
//                  IFID_UsesRt, IFID_MemWrite, IDEX_Valid, IDEX_MemRead,
//                  IDEX_RegisterRd, IDEX_MulStart
//  slave drives  : PCWrite, IFIDWrite, IDEXWrite, IDEX_Flush, EXMEM_Flush,
//                  MemFwd, mul_busy, stall_cycles[CNT_W-1:0]
//  CNT_W must match the CNT_W of the pipe_hazard_stall instance it connects to.
interface pipe_hazard_stall_if #(
    parameter int CNT_W = 16
);
    logic             IFID_Valid;
    logic [4:0]       IFID_RegisterRs;
    logic [4:0]       IFID_RegisterRt;
    logic             IFID_UsesRs;
    logic             IFID_UsesRt;
    logic             IFID_MemWrite;
    logic             IDEX_Valid;
    logic             IDEX_MemRead;
    logic [4:0]       IDEX_RegisterRd;
    logic             IDEX_MulStart;
    logic             PCWrite;
    logic             IFIDWrite;
    logic             IDEXWrite;
    logic             IDEX_Flush;
    logic             EXMEM_Flush;
    logic             MemFwd;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output IFID_Valid, IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRs,
               IFID_UsesRt, IFID_MemWrite, IDEX_Valid, IDEX_MemRead,
               IDEX_RegisterRd, IDEX_MulStart,
        input  PCWrite, IFIDWrite, IDEXWrite, IDEX_Flush, EXMEM_Flush,
               MemFwd, mul_busy, stall_cycles
    );

    modport slave (
        input  IFID_Valid, IFID_RegisterRs, IFID_RegisterRt, IFID_UsesRs,
               IFID_UsesRt, IFID_MemWrite, IDEX_Valid, IDEX_MemRead,
               IDEX_RegisterRd, IDEX_MulStart,
        output PCWrite, IFIDWrite, IDEXWrite, IDEX_Flush, EXMEM_Flush,
               MemFwd, mul_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_stall.sv
// pipe_hazard_stall
//  ID-stage stall unit. Stalls the front end on a load-use hazard that
//  forwarding cannot cover, and for the extra cycles a multi-cycle multiply
//  occupies EX. Also counts stalled cycles (saturating).
//  Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high; forces all enables high while asserted
//   bus    : pipe_hazard_stall_if.slave (pipeline register fields in,
//            write enables / bubble inserts / MemFwd / mul_busy / stall_cycles out)
//  Parameters:
//   MUL_LAT : cycles a multiply occupies EX (1..15)
//   CNT_W   : stall counter width
//  Build option:
//   MEM_TO_MEM_FWD_EN : when defined, a lw feeding only the store data (rt) of
//   a following sw does not stall; the data is forwarded MEM/WB -> MEM (MemFwd).
module pipe_hazard_stall #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_stall_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Multiply stalls MUL_LAT-1 cycles: the start cycle is free, then BUSY runs
    // cnt = MUL_LAT-2 down to 0 inclusive.
    localparam bit         MUL_MULTI = (MUL_LAT > 1);
    localparam logic [3:0] CNT_LOAD  = MUL_MULTI ? 4'(MUL_LAT - 2) : 4'd0;

    logic [0:0]       state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] stall_cnt;

    logic rs_hit;
    logic rt_hit;
    logic rt_hit_eff;
    logic load_in_ex;
    logic load_use;
    logic mem_fwd;
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic idex_flush;
    logic exmem_flush;

    assign rs_hit = bus.IFID_UsesRs && (bus.IFID_RegisterRs == bus.IDEX_RegisterRd);
    assign rt_hit = bus.IFID_UsesRt && (bus.IFID_RegisterRt == bus.IDEX_RegisterRd);

    // $0 is hardwired, so a load targeting it can never create a dependence.
    assign load_in_ex = bus.IFID_Valid && bus.IDEX_Valid && bus.IDEX_MemRead
                        && (bus.IDEX_RegisterRd != 5'd0);

`ifdef MEM_TO_MEM_FWD_EN
    // A store whose only dependence is its data operand can pick the loaded
    // value up one stage later, from MEM/WB, instead of waiting in ID.
    logic sw_data_only;
    assign sw_data_only = bus.IFID_MemWrite && rt_hit && !rs_hit;
    assign rt_hit_eff   = rt_hit && !sw_data_only;
    assign mem_fwd      = !reset && (state == IDLE) && load_in_ex && sw_data_only;
`else
    logic unused_mem_write;
    assign unused_mem_write = bus.IFID_MemWrite;
    assign rt_hit_eff       = rt_hit;
    assign mem_fwd          = 1'b0;
`endif

    assign load_use = load_in_ex && (rs_hit || rt_hit_eff);

    // Enable/bubble decode. BUSY freezes everything up to ID/EX and feeds
    // bubbles into EX/MEM; a load-use in IDLE holds PC/IFID and drops a bubble
    // into ID/EX so the load moves on to MEM.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset) begin
            if (state == BUSY) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
            end else if (load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    // Multiply occupancy FSM and saturating stall counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.IDEX_Valid && bus.IDEX_MulStart && MUL_MULTI) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite      = pc_write;
    assign bus.IFIDWrite    = ifid_write;
    assign bus.IDEXWrite    = idex_write;
    assign bus.IDEX_Flush   = idex_flush;
    assign bus.EXMEM_Flush  = exmem_flush;
    assign bus.MemFwd       = mem_fwd;
    assign bus.mul_busy     = !reset && (state == BUSY);
    assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_stall.sv
// tb_pipe_hazard_stall
//  Directed bench for pipe_hazard_stall (MUL_LAT=4). A second instance with a
//  3-bit stall counter shares the same stimulus to reach counter saturation.
//  A reference model tracks remaining multiply stall cycles and total stalls;
//  it is compared with both instances every cycle, and literal expectations
//  pin the model at key points of each scenario.
module tb_pipe_hazard_stall;
    localparam int MUL_LAT = 4;

    typedef struct packed {
        logic       rst;
        logic       ifv;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mw;
        logic       idv;
        logic       mr;
        logic [4:0] rd;
        logic       ms;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic compare_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mul_left = 0;
    int   stall_total = 0;

    pipe_hazard_stall_if #(.CNT_W(16)) bus ();
    pipe_hazard_stall_if #(.CNT_W(3))  small_bus ();

    pipe_hazard_stall #(.MUL_LAT(MUL_LAT), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipe_hazard_stall #(.MUL_LAT(MUL_LAT), .CNT_W(3)) dut_small (
        .clk   (clk),
        .reset (reset),
        .bus   (small_bus.slave)
    );

    assign small_bus.IFID_Valid      = bus.IFID_Valid;
    assign small_bus.IFID_RegisterRs = bus.IFID_RegisterRs;
    assign small_bus.IFID_RegisterRt = bus.IFID_RegisterRt;
    assign small_bus.IFID_UsesRs     = bus.IFID_UsesRs;
    assign small_bus.IFID_UsesRt     = bus.IFID_UsesRt;
    assign small_bus.IFID_MemWrite   = bus.IFID_MemWrite;
    assign small_bus.IDEX_Valid      = bus.IDEX_Valid;
    assign small_bus.IDEX_MemRead    = bus.IDEX_MemRead;
    assign small_bus.IDEX_RegisterRd = bus.IDEX_RegisterRd;
    assign small_bus.IDEX_MulStart   = bus.IDEX_MulStart;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic vec_t mk(logic ifv, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic mw, logic idv,
                                logic mr, logic [4:0] rd, logic ms);
        vec_t v;
        v.rst = 1'b0;
        v.ifv = ifv; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mw = mw;
        v.idv = idv; v.mr = mr; v.rd = rd; v.ms = ms;
        return v;
    endfunction

    function automatic vec_t nop();
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endfunction

    // Drive one cycle of inputs just after the rising edge, then return at the
    // falling edge so the caller can sample settled outputs.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset                = v.rst;
        bus.IFID_Valid       = v.ifv;
        bus.IFID_RegisterRs  = v.rs;
        bus.IFID_RegisterRt  = v.rt;
        bus.IFID_UsesRs      = v.urs;
        bus.IFID_UsesRt      = v.urt;
        bus.IFID_MemWrite    = v.mw;
        bus.IDEX_Valid       = v.idv;
        bus.IDEX_MemRead     = v.mr;
        bus.IDEX_RegisterRd  = v.rd;
        bus.IDEX_MulStart    = v.ms;
        @(negedge clk);
    endtask

    // Reference rules: does the current ID instruction need an operand the
    // load in EX has not produced yet, and is it a store that can instead take
    // its data from MEM/WB?
    function automatic bit model_store_fwd();
`ifdef MEM_TO_MEM_FWD_EN
        return bus.IFID_MemWrite && bus.IFID_UsesRt
               && bus.IFID_RegisterRt == bus.IDEX_RegisterRd
               && !(bus.IFID_UsesRs && bus.IFID_RegisterRs == bus.IDEX_RegisterRd);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_load_use();
        bit needs;
        if (!(bus.IFID_Valid && bus.IDEX_Valid && bus.IDEX_MemRead)) return 1'b0;
        if (bus.IDEX_RegisterRd == 5'd0) return 1'b0;
        needs = 1'b0;
        if (bus.IFID_UsesRs && bus.IFID_RegisterRs == bus.IDEX_RegisterRd) needs = 1'b1;
        if (bus.IFID_UsesRt && bus.IFID_RegisterRt == bus.IDEX_RegisterRd
            && !model_store_fwd()) needs = 1'b1;
        return needs;
    endfunction

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (compare_en) begin
            bit busy;
            bit lu;
            bit fwd;
            int sat16;
            int sat3;
            busy  = !reset && mul_left > 0;
            lu    = !reset && !busy && model_load_use();
            fwd   = !reset && !busy && model_load_use() == 1'b0 && bus.IFID_Valid
                    && bus.IDEX_Valid && bus.IDEX_MemRead && bus.IDEX_RegisterRd != 5'd0
                    && model_store_fwd();
            sat16 = stall_total > 65535 ? 65535 : stall_total;
            sat3  = stall_total > 7 ? 7 : stall_total;
            checkOutput("PCWrite",      bus.PCWrite,     !(busy || lu));
            checkOutput("IFIDWrite",    bus.IFIDWrite,   !(busy || lu));
            checkOutput("IDEXWrite",    bus.IDEXWrite,   !busy);
            checkOutput("IDEX_Flush",   bus.IDEX_Flush,  lu);
            checkOutput("EXMEM_Flush",  bus.EXMEM_Flush, busy);
            checkOutput("MemFwd",       bus.MemFwd,      fwd);
            checkOutput("mul_busy",     bus.mul_busy,    busy);
            checkOutput("stall_cycles", bus.stall_cycles, sat16);
            checkOutput("small_stall_cycles", small_bus.stall_cycles, sat3);
        end
    end

    // Model state advance at the active edge.
    always @(posedge clk) begin
        if (reset) begin
            mul_left    = 0;
            stall_total = 0;
        end else begin
            if (mul_left > 0 || model_load_use()) stall_total++;
            if (mul_left > 0) begin
                mul_left--;
            end else if (bus.IDEX_Valid && bus.IDEX_MulStart && MUL_LAT > 1) begin
                mul_left = MUL_LAT - 1;
            end
        end
    end

    initial begin
        vec_t v;
        vec_t add5;
        vec_t mulv;
        vec_t lu4;

        bus.IFID_Valid = 1'b0; bus.IFID_RegisterRs = 5'd0; bus.IFID_RegisterRt = 5'd0;
        bus.IFID_UsesRs = 1'b0; bus.IFID_UsesRt = 1'b0; bus.IFID_MemWrite = 1'b0;
        bus.IDEX_Valid = 1'b0; bus.IDEX_MemRead = 1'b0; bus.IDEX_RegisterRd = 5'd0;
        bus.IDEX_MulStart = 1'b0;
        repeat (2) @(posedge clk);
        #1 compare_en = 1'b1;

        // Reset holds enables high even with a load-use pattern present.
        v = mk(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
        v.rst = 1'b1;
        applyStimulus(v);
        checkOutput("lit_reset_pc", bus.PCWrite, 1);
        checkOutput("lit_reset_cnt", bus.stall_cycles, 0);

        // T1: lw $5 in EX, add using $5 in ID.
        add5 = mk(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
        applyStimulus(add5);
        checkOutput("lit_t1_pc", bus.PCWrite, 0);
        checkOutput("lit_t1_flush", bus.IDEX_Flush, 1);
        add5.idv = 1'b0;
        applyStimulus(add5);
        checkOutput("lit_t1_after_pc", bus.PCWrite, 1);
        checkOutput("lit_t1_cnt", bus.stall_cycles, 1);

        // T2: load to $0 never stalls; invalid stages never stall.
        applyStimulus(mk(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0));
        checkOutput("lit_t2_pc", bus.PCWrite, 1);
        applyStimulus(mk(1'b0, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0));
        checkOutput("lit_ifid_invalid_pc", bus.PCWrite, 1);

        // rt dependence on a non-store stalls.
        applyStimulus(mk(1'b1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0));
        checkOutput("lit_rt_pc", bus.PCWrite, 0);
        applyStimulus(nop());
        checkOutput("lit_rt_cnt", bus.stall_cycles, 2);

        // T3: multiply in EX, one free cycle then three stall cycles.
        mulv = mk(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
        applyStimulus(mulv);
        checkOutput("lit_t3_start_busy", bus.mul_busy, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mulv);
            checkOutput("lit_t3_busy", bus.mul_busy, 1);
            checkOutput("lit_t3_exflush", bus.EXMEM_Flush, 1);
        end
        applyStimulus(nop());
        checkOutput("lit_t3_done_busy", bus.mul_busy, 0);
        checkOutput("lit_t3_cnt", bus.stall_cycles, 5);

        // T4: lw $7 then sw rt=$7 rs=$2.
        applyStimulus(mk(1'b1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0));
`ifdef MEM_TO_MEM_FWD_EN
        checkOutput("lit_t4_pc", bus.PCWrite, 1);
        checkOutput("lit_t4_memfwd", bus.MemFwd, 1);
`else
        checkOutput("lit_t4_pc", bus.PCWrite, 0);
        checkOutput("lit_t4_memfwd", bus.MemFwd, 0);
`endif
        // Store address dependence always stalls.
        applyStimulus(mk(1'b1, 5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0));
        checkOutput("lit_t4_addr_pc", bus.PCWrite, 0);
        checkOutput("lit_t4_addr_memfwd", bus.MemFwd, 0);

        // T5: reset during the second BUSY cycle.
        applyStimulus(mulv);
        applyStimulus(mulv);
        checkOutput("lit_t5_busy1", bus.mul_busy, 1);
        v = mulv;
        v.rst = 1'b1;
        applyStimulus(v);
        checkOutput("lit_t5_rst_busy", bus.mul_busy, 0);
        checkOutput("lit_t5_rst_pc", bus.PCWrite, 1);
        applyStimulus(nop());
        checkOutput("lit_t5_busy", bus.mul_busy, 0);
        checkOutput("lit_t5_cnt", bus.stall_cycles, 0);
        checkOutput("lit_t5_pc", bus.PCWrite, 1);

        // T6: sustained load-use drives the 3-bit counter into saturation.
        lu4 = mk(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(lu4);
        end
        checkOutput("lit_t6_small_at8", small_bus.stall_cycles, 7);
        applyStimulus(nop());
        checkOutput("lit_t6_small_hold", small_bus.stall_cycles, 7);
        checkOutput("lit_t6_main", bus.stall_cycles, 9);

        applyStimulus(nop());
        compare_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
